// File: rtl/uart_pkg.sv
// Shared UART definitions: bit-rate divider math, counter width and the
// receive state encoding, common to the receiver and the transmitter.
package uart_pkg;

  localparam int CNT_W        = 13;
  localparam int BAUD_DIV_MIN = 4;
  localparam int BAUD_DIV_MAX = (1 << CNT_W) - 1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } uart_state_t;

  // Clocks per serial bit, truncated.
  function automatic int calc_baud_div(input int clk_mhz, input int baud_rate);
    return (clk_mhz * 1000000) / baud_rate;
  endfunction

  // Offset from the start edge to the middle of the start bit.
  function automatic int calc_half_div(input int baud_div);
    return baud_div / 2;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the
// idle (high) level so a reset never looks like a start edge.
module uart_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the raw line through two flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first. Samples mid-bit using an up-counting baud
// counter restarted at each sample point; holds one byte for the consumer.
//
//  state        | meaning
//  -------------+-----------------------------------------------------
//  ST_IDLE      | line idle, waiting for rxs=0
//  ST_START     | confirm start bit at its midpoint (glitch filter)
//  ST_DATA      | sample 8 data bits, one per bit period
//  ST_STOP      | sample stop bit; deliver byte or flag framing error
//  ST_WAIT_HIGH | bad stop / break: wait for the line to return high
module uart_rx
  import uart_pkg::*;
#(
  parameter int BAUD_RATE   = 115200,
  parameter int CLK_VAL_MHZ = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       frame_err,
  output logic       overrun
);

  localparam int BAUD_DIV = calc_baud_div(CLK_VAL_MHZ, BAUD_RATE);
  localparam int HALF_DIV = calc_half_div(BAUD_DIV);
  localparam logic [CNT_W-1:0] FULL_TC = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_TC = CNT_W'(HALF_DIV - 1);

  if (BAUD_DIV < BAUD_DIV_MIN || BAUD_DIV > BAUD_DIV_MAX) begin : g_div_range
    $error("uart_rx: BAUD_DIV out of range 4..8191");
  end

  uart_state_t      state_q, state_d;
  logic             rxs;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;
  logic             cnt_clr, shift_en, deliver, stop_bad;

  uart_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rxs)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic and per-cycle strobes for the datapath.
  always_comb begin
    state_d  = state_q;
    cnt_clr  = 1'b0;
    shift_en = 1'b0;
    deliver  = 1'b0;
    stop_bad = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rxs) begin
          state_d = ST_START;
          cnt_clr = 1'b1;
        end
      end
      ST_START: begin
        if (cnt_q == HALF_TC) begin
          cnt_clr = 1'b1;
          state_d = rxs ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt_q == FULL_TC) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
          if (bit_q == 3'd7) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (cnt_q == FULL_TC) begin
          cnt_clr = 1'b1;
          if (rxs) begin
            deliver = 1'b1;
            state_d = ST_IDLE;
          end else begin
            stop_bad = 1'b1;
            state_d  = ST_WAIT_HIGH;
          end
        end
      end
      ST_WAIT_HIGH: begin
        if (rxs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Baud counter: runs only while a frame is in progress.
  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else if (cnt_clr || state_q == ST_IDLE || state_q == ST_WAIT_HIGH)
      cnt_q <= '0;
    else
      cnt_q <= cnt_q + 1'b1;
  end

  // Data shift register, LSB arrives first so shift right.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_q   <= '0;
      shift_q <= '0;
    end else if (state_q == ST_START) begin
      bit_q <= '0;
    end else if (shift_en) begin
      shift_q <= {rxs, shift_q[7:1]};
      bit_q   <= bit_q + 1'b1;
    end
  end

  // Output holding register with ack handshake and overrun/framing pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      overrun   <= 1'b0;
      if (deliver) begin
        if (rx_valid && !rx_ack) begin
          overrun <= 1'b1;
        end else begin
          rx_data  <= shift_q;
          rx_valid <= 1'b1;
        end
      end else if (rx_ack) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at default parameters. Frames are driven bit by bit;
// expected delivery / error cycles come from the frame timing arithmetic.
module tb_uart_rx;

  localparam int BDIV  = (50 * 1000000) / 115200;
  localparam int HDIV  = BDIV / 2;
  localparam int LAT   = 3 + HDIV + 9 * BDIV;   // start drive -> output edge
  localparam int FRAME = 10 * BDIV;

  logic       clk, rst, rx, rx_ack;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun;

  int n_vec, n_err;
  int cyc;
  int rise_q[$], ferr_q[$], ovr_q[$];
  logic prev_valid;
  int ta, tb2;

  uart_rx dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ack    (rx_ack),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event log: cycle numbers of rx_valid rises and error pulses.
  initial prev_valid = 1'b0;
  always @(posedge clk) begin
    #1;
    if (rx_valid && !prev_valid) rise_q.push_back(cyc);
    if (frame_err) ferr_q.push_back(cyc);
    if (overrun) ovr_q.push_back(cyc);
    prev_valid = rx_valid;
  end

  task automatic clear_logs();
    rise_q.delete();
    ferr_q.delete();
    ovr_q.delete();
  endtask

  // Called at a negedge; returns at the negedge ending the stop bit.
  task automatic send_frame(input logic [7:0] b, input logic stop, output int t);
    t  = cyc;
    rx = 1'b0;
    repeat (BDIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BDIV) @(negedge clk);
    end
    rx = stop;
    repeat (BDIV) @(negedge clk);
  endtask

  task automatic do_ack();
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx = 1'b1; rx_ack = 1'b0;
    repeat (5) @(negedge clk);
    n_vec++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", rx_valid); end
    n_vec++; if (rx_data !== 8'h00) begin n_err++; $display("FAIL reset_data got=%h exp=00", rx_data); end
    n_vec++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_ferr got=%b exp=0", frame_err); end
    n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_ovr got=%b exp=0", overrun); end
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_basic();
    int t;
    clear_logs();
    send_frame(8'h55, 1'b1, t);
    repeat (20) @(negedge clk);
    n_vec++; if (rise_q.size() != 1 || rise_q[0] != t + LAT) begin n_err++; $display("FAIL basic_rise n=%0d exp_cycle=%0d", rise_q.size(), t + LAT); end
    n_vec++; if (rx_data !== 8'h55) begin n_err++; $display("FAIL basic_data got=%h exp=55", rx_data); end
    n_vec++; if (rx_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid got=%b exp=1", rx_valid); end
    n_vec++; if (ferr_q.size() != 0 || ovr_q.size() != 0) begin n_err++; $display("FAIL basic_err ferr=%0d ovr=%0d exp=0", ferr_q.size(), ovr_q.size()); end
    do_ack();
    n_vec++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL basic_ack got=%b exp=0", rx_valid); end
  endtask

  task automatic test_glitch();
    int t;
    clear_logs();
    rx = 1'b0;
    repeat (100) @(negedge clk);
    rx = 1'b1;
    repeat (400) @(negedge clk);
    n_vec++; if (rise_q.size() != 0 || ferr_q.size() != 0 || rx_valid !== 1'b0) begin n_err++; $display("FAIL glitch_quiet rise=%0d ferr=%0d valid=%b exp=0/0/0", rise_q.size(), ferr_q.size(), rx_valid); end
    send_frame(8'hA5, 1'b1, t);
    repeat (20) @(negedge clk);
    n_vec++; if (rise_q.size() != 1 || rise_q[0] != t + LAT) begin n_err++; $display("FAIL glitch_rise n=%0d exp_cycle=%0d", rise_q.size(), t + LAT); end
    n_vec++; if (rx_data !== 8'hA5) begin n_err++; $display("FAIL glitch_data got=%h exp=a5", rx_data); end
    do_ack();
  endtask

  task automatic test_break();
    int t;
    clear_logs();
    send_frame(8'h3C, 1'b0, t);
    repeat (3000) @(negedge clk);
    n_vec++; if (ferr_q.size() != 1 || ferr_q[0] != t + LAT) begin n_err++; $display("FAIL break_ferr n=%0d exp_cycle=%0d", ferr_q.size(), t + LAT); end
    n_vec++; if (rise_q.size() != 0 || rx_valid !== 1'b0) begin n_err++; $display("FAIL break_valid rise=%0d valid=%b exp=0/0", rise_q.size(), rx_valid); end
    rx = 1'b1;
    repeat (50) @(negedge clk);
    n_vec++; if (ferr_q.size() != 1 || rise_q.size() != 0) begin n_err++; $display("FAIL break_release ferr=%0d rise=%0d exp=1/0", ferr_q.size(), rise_q.size()); end
  endtask

  task automatic test_back_to_back();
    int t1, t2;
    clear_logs();
    send_frame(8'h12, 1'b1, t1);
    send_frame(8'h34, 1'b1, t2);
    repeat (20) @(negedge clk);
    n_vec++; if (rise_q.size() != 1 || rise_q[0] != t1 + LAT) begin n_err++; $display("FAIL b2b_rise n=%0d exp_cycle=%0d", rise_q.size(), t1 + LAT); end
    n_vec++; if (ovr_q.size() != 1 || ovr_q[0] != t2 + LAT) begin n_err++; $display("FAIL b2b_ovr n=%0d exp_cycle=%0d", ovr_q.size(), t2 + LAT); end
    n_vec++; if (rx_data !== 8'h12 || rx_valid !== 1'b1) begin n_err++; $display("FAIL b2b_data got=%h/%b exp=12/1", rx_data, rx_valid); end
    do_ack();
    n_vec++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL b2b_ack got=%b exp=0", rx_valid); end
  endtask

  task automatic test_ack_on_delivery();
    int t1;
    clear_logs();
    t1 = cyc;
    fork
      begin
        send_frame(8'h12, 1'b1, ta);
        send_frame(8'h34, 1'b1, tb2);
      end
      begin
        while (cyc < t1 + FRAME + LAT - 1) @(negedge clk);
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
      end
    join
    repeat (20) @(negedge clk);
    n_vec++; if (rise_q.size() != 1 || rise_q[0] != t1 + LAT) begin n_err++; $display("FAIL ackdel_rise n=%0d exp_cycle=%0d", rise_q.size(), t1 + LAT); end
    n_vec++; if (ovr_q.size() != 0) begin n_err++; $display("FAIL ackdel_ovr n=%0d exp=0", ovr_q.size()); end
    n_vec++; if (rx_data !== 8'h34 || rx_valid !== 1'b1) begin n_err++; $display("FAIL ackdel_data got=%h/%b exp=34/1", rx_data, rx_valid); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] pb;
    int t;
    pb = 8'($urandom);
    rx = 1'b0;
    repeat (BDIV) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = pb[i];
      repeat (BDIV) @(negedge clk);
    end
    rx = pb[3];
    repeat (BDIV / 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rx  = 1'b1;
    n_vec++; if (rx_valid !== 1'b0 || rx_data !== 8'h00) begin n_err++; $display("FAIL midrst_out got=%h/%b exp=00/0", rx_data, rx_valid); end
    n_vec++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin n_err++; $display("FAIL midrst_pulse ferr=%b ovr=%b exp=0/0", frame_err, overrun); end
    clear_logs();
    repeat (2 * BDIV) @(negedge clk);
    n_vec++; if (rise_q.size() != 0 || ferr_q.size() != 0) begin n_err++; $display("FAIL midrst_quiet rise=%0d ferr=%0d exp=0/0", rise_q.size(), ferr_q.size()); end
    send_frame(8'hC3, 1'b1, t);
    repeat (20) @(negedge clk);
    n_vec++; if (rise_q.size() != 1 || rise_q[0] != t + LAT || rx_data !== 8'hC3) begin n_err++; $display("FAIL midrst_c3 n=%0d data=%h exp_cycle=%0d exp=c3", rise_q.size(), rx_data, t + LAT); end
  endtask

  task automatic test_random();
    logic       mvalid;
    logic [7:0] mdata, b;
    logic       good;
    int t, exp_rise, exp_ovr, exp_ferr;
    mvalid = 1'b1;
    mdata  = 8'hC3;
    for (int k = 0; k < 5; k++) begin
      b    = 8'($urandom);
      good = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) begin
        do_ack();
        mvalid = 1'b0;
        n_vec++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL rnd%0d_ack got=%b exp=0", k, rx_valid); end
      end
      clear_logs();
      send_frame(b, good, t);
      exp_rise = -1; exp_ovr = -1; exp_ferr = -1;
      if (!good) begin
        exp_ferr = t + LAT;
        repeat ($urandom_range(50, 500)) @(negedge clk);
        rx = 1'b1;
      end else if (mvalid) begin
        exp_ovr = t + LAT;
      end else begin
        exp_rise = t + LAT;
        mvalid   = 1'b1;
        mdata    = b;
      end
      repeat (20) @(negedge clk);
      n_vec++; if (rx_valid !== mvalid || rx_data !== mdata) begin n_err++; $display("FAIL rnd%0d_out got=%h/%b exp=%h/%b", k, rx_data, rx_valid, mdata, mvalid); end
      n_vec++; if (exp_rise < 0 ? rise_q.size() != 0 : (rise_q.size() != 1 || rise_q[0] != exp_rise)) begin n_err++; $display("FAIL rnd%0d_rise n=%0d exp_cycle=%0d", k, rise_q.size(), exp_rise); end
      n_vec++; if (exp_ovr < 0 ? ovr_q.size() != 0 : (ovr_q.size() != 1 || ovr_q[0] != exp_ovr)) begin n_err++; $display("FAIL rnd%0d_ovr n=%0d exp_cycle=%0d", k, ovr_q.size(), exp_ovr); end
      n_vec++; if (exp_ferr < 0 ? ferr_q.size() != 0 : (ferr_q.size() != 1 || ferr_q[0] != exp_ferr)) begin n_err++; $display("FAIL rnd%0d_ferr n=%0d exp_cycle=%0d", k, ferr_q.size(), exp_ferr); end
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b1; rx = 1'b1; rx_ack = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_glitch();
    test_break();
    test_back_to_back();
    test_ack_on_delivery();
    test_reset_mid_frame();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
